// File: rtl/reaction_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer_core
// Brief    : Millisecond reaction timer (count up / count down) and
//            fixed-length game-seconds timer for the reaction-game FSM.
// Revision : 1.0
// ============================================================================
module reaction_timer_core #(
    parameter int CLKS_PER_MS = 50000,
    parameter int MAX_MS      = 2047,
    parameter int MS_PER_S    = 1000,
    parameter int GAME_MAX_S  = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reset,
    input  logic        up,
    input  logic        enable,
    input  logic [10:0] start_value,
    input  logic        game_reset,
    input  logic        game_timer_enable,
    output logic [10:0] timer_value,
    output logic        expired,
    output logic        overflow,
    output logic [5:0]  game_timer_value,
    output logic        game_over
);

    localparam int                 c_MS_CNT_W = $clog2(CLKS_PER_MS);
    localparam int                 c_S_CNT_W  = $clog2(MS_PER_S);
    localparam logic [c_MS_CNT_W-1:0] c_MS_LAST = c_MS_CNT_W'(CLKS_PER_MS - 1);
    localparam logic [c_S_CNT_W-1:0]  c_S_LAST  = c_S_CNT_W'(MS_PER_S - 1);
    localparam logic [10:0]        c_MAX_MS   = 11'(MAX_MS);
    localparam logic [5:0]         c_GAME_MAX = 6'(GAME_MAX_S);

    logic [c_MS_CNT_W-1:0] r_ms_cnt;
    logic [10:0]           r_timer_value;
    logic                  r_expired;
    logic                  r_overflow;
    logic [c_MS_CNT_W-1:0] r_g_clk_cnt;
    logic [c_S_CNT_W-1:0]  r_g_ms_cnt;
    logic [5:0]            r_game_timer;

    logic w_ms_tick;
    logic w_g_ms_tick;
    logic w_s_tick;

    assign w_ms_tick   = enable && (r_ms_cnt == c_MS_LAST);
    assign w_g_ms_tick = game_timer_enable && (r_g_clk_cnt == c_MS_LAST);
    assign w_s_tick    = w_g_ms_tick && (r_g_ms_cnt == c_S_LAST);

    // Reaction timer: the prescaler only advances while enabled so a pause
    // neither loses nor adds a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ms_cnt      <= '0;
            r_timer_value <= '0;
            r_expired     <= 1'b0;
            r_overflow    <= 1'b0;
        end else if (reset) begin
            r_ms_cnt      <= '0;
            r_timer_value <= up ? 11'd0 : start_value;
            r_expired     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (w_ms_tick) begin
                r_ms_cnt <= '0;
                if (up) begin
                    if (r_timer_value < c_MAX_MS) begin
                        r_timer_value <= r_timer_value + 11'd1;
                        if (r_timer_value + 11'd1 == c_MAX_MS)
                            r_overflow <= 1'b1;
                    end
                end else if (r_timer_value != 11'd0) begin
                    r_timer_value <= r_timer_value - 11'd1;
                    if (r_timer_value == 11'd1)
                        r_expired <= 1'b1;
                end
            end else if (enable) begin
                r_ms_cnt <= r_ms_cnt + 1'b1;
            end
        end
    end

    // Game timer: two cascaded prescalers feed a saturating seconds counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g_clk_cnt  <= '0;
            r_g_ms_cnt   <= '0;
            r_game_timer <= '0;
        end else if (game_reset) begin
            r_g_clk_cnt  <= '0;
            r_g_ms_cnt   <= '0;
            r_game_timer <= '0;
        end else if (game_timer_enable) begin
            if (w_g_ms_tick) begin
                r_g_clk_cnt <= '0;
                r_g_ms_cnt  <= (r_g_ms_cnt == c_S_LAST) ? '0 : r_g_ms_cnt + 1'b1;
            end else begin
                r_g_clk_cnt <= r_g_clk_cnt + 1'b1;
            end
            if (w_s_tick && (r_game_timer < c_GAME_MAX))
                r_game_timer <= r_game_timer + 6'd1;
        end
    end

    assign timer_value      = r_timer_value;
    assign expired          = r_expired;
    assign overflow         = r_overflow;
    assign game_timer_value = r_game_timer;
    assign game_over        = (r_game_timer == c_GAME_MAX);

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_reaction_timer_core
// Brief    : Directed self-checking bench for reaction_timer_core.
// Revision : 1.0
// ============================================================================
module tb_reaction_timer_core;

    localparam int c_CLKS = 4;
    localparam int c_MSPS = 5;
    localparam int c_GMAX = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reset = 1'b0;
    logic        up = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] start_value = 11'd0;
    logic        game_reset = 1'b0;
    logic        game_timer_enable = 1'b0;

    logic [10:0] timer_value;
    logic        expired;
    logic        overflow;
    logic [5:0]  game_timer_value;
    logic        game_over;

    logic [10:0] sat_timer_value;
    logic        sat_expired;
    logic        sat_overflow;
    logic [5:0]  sat_game_timer_value;
    logic        sat_game_over;

    int n_checks = 0;
    int n_fail   = 0;

    reaction_timer_core #(
        .CLKS_PER_MS(c_CLKS), .MAX_MS(2047), .MS_PER_S(c_MSPS), .GAME_MAX_S(c_GMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .reset(reset), .up(up), .enable(enable),
        .start_value(start_value), .game_reset(game_reset),
        .game_timer_enable(game_timer_enable), .timer_value(timer_value),
        .expired(expired), .overflow(overflow),
        .game_timer_value(game_timer_value), .game_over(game_over)
    );

    reaction_timer_core #(
        .CLKS_PER_MS(c_CLKS), .MAX_MS(5), .MS_PER_S(c_MSPS), .GAME_MAX_S(c_GMAX)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .reset(reset), .up(up), .enable(enable),
        .start_value(start_value), .game_reset(game_reset),
        .game_timer_enable(game_timer_enable), .timer_value(sat_timer_value),
        .expired(sat_expired), .overflow(sat_overflow),
        .game_timer_value(sat_game_timer_value), .game_over(sat_game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_timer", timer_value, 0);
        chk("rst_expired", expired, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_game", game_timer_value, 0);
        chk("rst_game_over", game_over, 0);
        step(1);
        rst_n = 1'b1;

        // Up-count and saturation (MAX_MS=5 instance)
        reset = 1'b1; up = 1'b1; enable = 1'b0;
        step(1);
        chk("up_load", timer_value, 0);
        reset = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            chk("up_val", timer_value, k / 4);
            chk("sat_val", sat_timer_value, (k / 4 > 5) ? 5 : k / 4);
            chk("sat_ovf", sat_overflow, (k >= 20) ? 1 : 0);
        end
        chk("up_ovf", overflow, 0);
        reset = 1'b1;
        step(1);
        chk("sat_clr_val", sat_timer_value, 0);
        chk("sat_clr_ovf", sat_overflow, 0);
        chk("up_clr_val", timer_value, 0);

        // Pause and priority
        reset = 1'b0;
        step(6);
        chk("pause_pre", timer_value, 1);
        enable = 1'b0;
        step(6);
        chk("pause_hold", timer_value, 1);
        enable = 1'b1;
        step(1);
        chk("pause_no_extra", timer_value, 1);
        step(1);
        chk("pause_no_lost", timer_value, 2);
        step(3);
        reset = 1'b1; up = 1'b0; start_value = 11'd7;
        step(1);
        chk("load_beats_tick", timer_value, 7);
        reset = 1'b0;
        step(3);
        chk("latency_hold", timer_value, 7);
        step(1);
        chk("latency_first", timer_value, 6);
        up = 1'b1;
        step(4);
        chk("dir_change", timer_value, 7);

        // Countdown with expiry pulse
        reset = 1'b1; up = 1'b0; start_value = 11'd3;
        step(1);
        chk("dn_load", timer_value, 3);
        chk("dn_load_exp", expired, 0);
        reset = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            step(1);
            chk("dn_val", timer_value, (k >= 12) ? 0 : 3 - k / 4);
            chk("dn_exp", expired, (k == 12) ? 1 : 0);
        end

        // Zero load in down mode
        reset = 1'b1; start_value = 11'd0;
        step(1);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("zero_val", timer_value, 0);
            chk("zero_exp", expired, 0);
        end

        // Game timer, with the reaction timer counting up alongside
        reset = 1'b1; up = 1'b1; game_reset = 1'b1; game_timer_enable = 1'b1;
        step(1);
        chk("g_clr", game_timer_value, 0);
        chk("g_clr_over", game_over, 0);
        reset = 1'b0; game_reset = 1'b0;
        for (int k = 1; k <= 1220; k++) begin
            step(1);
            chk("g_val", game_timer_value, (k / 20 > 60) ? 60 : k / 20);
            chk("g_over", game_over, (k >= 1200) ? 1 : 0);
        end
        chk("g_side_timer", timer_value, 305);
        reset = 1'b1; game_reset = 1'b1;
        step(1);
        chk("both_clr_timer", timer_value, 0);
        chk("both_clr_game", game_timer_value, 0);
        chk("both_clr_over", game_over, 0);
        reset = 1'b0; game_reset = 1'b0;
        step(19);
        chk("g_restart_hold", game_timer_value, 0);
        chk("g_restart_timer", timer_value, 4);
        step(1);
        chk("g_restart_first", game_timer_value, 1);
        step(6);

        // Asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_timer", timer_value, 0);
        chk("async_game", game_timer_value, 0);
        chk("async_sat_ovf", sat_overflow, 0);
        chk("async_sat_timer", sat_timer_value, 0);
        chk("async_over", game_over, 0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("async_rel_hold", timer_value, 0);
        step(1);
        chk("async_rel_first", timer_value, 1);
        step(15);
        chk("async_rel_ghold", game_timer_value, 0);
        step(1);
        chk("async_rel_gfirst", game_timer_value, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
- Timer responder for the reaction-time game FSM.
- The FSM drives `reset`/`up`/`enable`/`game_reset`/`game_timer_enable`; this block returns `timer_value` (ms), `game_timer_value` (s) and status flags.
- It provides the random-delay countdown before the LED lights, the reaction count-up after it lights, and the fixed-length game clock.
- Sits between the 50 MHz clock domain and the FSM; all logic is single-clock.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per millisecond tick (≥2).
- MAX_MS, 2047, saturation value of `timer_value` in up mode (≤2047).
- MS_PER_S, 1000, millisecond ticks per game-second tick (≥2).
- GAME_MAX_S, 60, saturation value of `game_timer_value` (≤63).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- reset  input  1  synchronous clear/load of the reaction timer (from FSM).
- up  input  1  1 = count up from 0; 0 = count down from `start_value`.
- enable  input  1  reaction timer run enable.
- start_value  input  11  countdown start in ms, sampled when `reset`=1 and `up`=0.
- game_reset  input  1  synchronous clear of the game timer.
- game_timer_enable  input  1  game timer run enable.
- timer_value  output  11  reaction timer value in ms.
- expired  output  1  one-cycle pulse when the countdown reaches 0.
- overflow  output  1  sticky; up-count hit MAX_MS.
- game_timer_value  output  6  elapsed game seconds.
- game_over  output  1  level; `game_timer_value == GAME_MAX_S`.

Behaviour:
- rst_n=0 (async):
  - All counters and prescalers clear.
  - `timer_value`=0, `expired`=0, `overflow`=0, `game_timer_value`=0, `game_over`=0.
- Priority per timer: rst_n > synchronous clear > tick.

Reaction path:
- Prescaler `ms_cnt` runs 0..CLKS_PER_MS-1 only while `enable`=1; it holds (pauses) while `enable`=0.
- `ms_tick` = `enable` && `ms_cnt == CLKS_PER_MS-1`; `ms_cnt` wraps to 0 on the tick.
- `reset`=1:
  - `ms_cnt`←0, `overflow`←0, `expired`←0.
  - `timer_value`←0 if `up`=1, else `timer_value`←`start_value`.
  - `reset` overrides `enable` in the same cycle.
- `ms_tick` with `up`=1:
  - If `timer_value` < MAX_MS, increment.
  - If the new value == MAX_MS, set `overflow`.
  - At MAX_MS the value holds and `overflow` stays 1 until `reset`.
- `ms_tick` with `up`=0:
  - If `timer_value` > 0, decrement.
  - On the 1→0 transition, `expired`=1 for exactly one cycle, registered with the new value.
  - At 0 the value holds and no further pulse is generated.
- Changing `up` mid-count does not clear; counting continues from the current value in the new direction.
- Latency: from `reset` release with `enable`=1, the first change appears after CLKS_PER_MS rising edges.
- `start_value`=0 loaded in down mode: `timer_value` stays 0 and `expired` never pulses.

Game path:
- Independent prescaler `g_clk_cnt` (0..CLKS_PER_MS-1) and `g_ms_cnt` (0..MS_PER_S-1).
- Both advance only while `game_timer_enable`=1; they pause otherwise.
- `s_tick` fires when both prescalers are at terminal count.
- On `s_tick`, `game_timer_value` increments if < GAME_MAX_S; it saturates at GAME_MAX_S.
- `game_over` is combinational from the registered value.
- `game_reset`=1 clears `g_clk_cnt`, `g_ms_cnt` and `game_timer_value`, overriding enable.
- `reset` and `game_reset` are independent; simultaneous assertion clears both paths.
- rst_n asserted mid-count clears immediately, without waiting for a clock edge.

Test Plan:
Test parameters: CLKS_PER_MS=4, MS_PER_S=5, GAME_MAX_S=60.
1. Up-count: `reset`=1,`up`=1 for 1 cycle, then `enable`=1 for 40 cycles -> `timer_value`=10. Value changes only every 4th edge, `overflow`=0.
2. Countdown: `reset`=1,`up`=0,`start_value`=3, then `enable`=1 -> 3,2,1,0 at 4-cycle spacing. `expired` is high for exactly 1 cycle, coincident with 0. Value holds 0 for a further 20 cycles with no pulse.
3. Saturation: MAX_MS=5 build, `up`=1, `enable`=1 for 40 cycles -> `timer_value` holds 5, `overflow`=1. A `reset` pulse -> `timer_value`=0, `overflow`=0.
4. Pause/priority: `enable` toggled 0 for 6 cycles mid-count -> value and prescaler frozen, resuming with no lost or extra tick. `reset`=1 together with `enable` at tick -> load wins.
5. Game timer: `game_timer_enable`=1 for 20×61 cycles -> `game_timer_value` reaches 60 after 1200 cycles and stays 60, `game_over`=1. `game_reset` -> 0, `game_over`=0.
6. Async reset: drop rst_n between clock edges mid-count -> all outputs 0 before the next edge. Release -> counting restarts with a full prescaler period.
